// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port VRAM arbiter: scanout has absolute priority, CPU uses idle slots,
// fixed 2-clock read return through a tag pipe.
module vram_arbiter #(
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int DATA_W     = 8,
  parameter int STARVE_MAX = 1024,
  localparam int AW        = $clog2(WIDTH * HEIGHT),
  localparam int XW        = $clog2(WIDTH),
  localparam int YW        = $clog2(HEIGHT)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              disp_en,
  input  logic [XW-1:0]     disp_x,
  input  logic [YW-1:0]     disp_y,
  output logic [DATA_W-1:0] disp_pixel,
  output logic              disp_pvalid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [AW-1:0]     cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  output logic              cpu_starved,
  output logic [AW-1:0]     mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {T_NONE, T_DISP, T_CPU_RD} tag_e;
  typedef enum logic [1:0] {C_IDLE, C_WAIT, C_ISSUED} cpu_state_e;
  typedef enum logic [1:0] {S_IDLE, S_DISP, S_CPU} slot_e;

  cpu_state_e        state_q, state_d;
  tag_e              tag1_q, tag1_d, tag2_q, tag2_d;
  logic              zero1_q, zero1_d, zero2_q, zero2_d;
  logic [AW-1:0]     mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] disp_pixel_q, disp_pixel_d;
  logic              disp_pvalid_q, disp_pvalid_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic              cpu_rvalid_q, cpu_rvalid_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  slot_e             slot;
  logic              disp_in_range;
  logic              cpu_in_range;
  logic [AW-1:0]     disp_lin_addr;

  assign cpu_ready   = (state_q == C_ISSUED);
  assign cpu_starved = (32'(cnt_q) >= STARVE_MAX);
  assign mem_addr    = mem_addr_q;
  assign mem_we      = mem_we_q;
  assign mem_wdata   = mem_wdata_q;
  assign disp_pixel  = disp_pixel_q;
  assign disp_pvalid = disp_pvalid_q;
  assign cpu_rdata   = cpu_rdata_q;
  assign cpu_rvalid  = cpu_rvalid_q;

  always_comb begin
    disp_in_range = (32'(disp_x) < WIDTH) && (32'(disp_y) < HEIGHT);
    cpu_in_range  = (32'(cpu_addr) < WIDTH * HEIGHT);
    disp_lin_addr = AW'(disp_y) * AW'(WIDTH) + AW'(disp_x);

    // cpu_ready marks the request just issued, so it is never granted twice
    if (disp_en)                 slot = S_DISP;
    else if (cpu_req && !cpu_ready) slot = S_CPU;
    else                         slot = S_IDLE;
  end

  always_comb begin
    state_d       = state_q;
    tag1_d        = T_NONE;
    zero1_d       = 1'b0;
    tag2_d        = tag1_q;
    zero2_d       = zero1_q;
    mem_addr_d    = mem_addr_q;
    mem_we_d      = 1'b0;
    mem_wdata_d   = mem_wdata_q;
    disp_pixel_d  = disp_pixel_q;
    disp_pvalid_d = 1'b0;
    cpu_rdata_d   = cpu_rdata_q;
    cpu_rvalid_d  = 1'b0;
    cnt_d         = '0;

    case (slot)
      S_DISP: begin
        tag1_d  = T_DISP;
        zero1_d = !disp_in_range;
        if (disp_in_range) mem_addr_d = disp_lin_addr;
      end
      S_CPU: begin
        tag1_d  = cpu_we ? T_NONE : T_CPU_RD;
        zero1_d = !cpu_in_range;
        if (cpu_in_range) begin
          mem_addr_d  = cpu_addr;
          mem_we_d    = cpu_we;
          mem_wdata_d = cpu_wdata;
        end
      end
      default: ;
    endcase

    // Out-of-range accesses never touched the RAM, so their returned data is forced to 0
    if (tag2_q == T_DISP) begin
      disp_pvalid_d = 1'b1;
      disp_pixel_d  = zero2_q ? '0 : mem_rdata;
    end
    if (tag2_q == T_CPU_RD) begin
      cpu_rvalid_d = 1'b1;
      cpu_rdata_d  = zero2_q ? '0 : mem_rdata;
    end

    if (cpu_req && !cpu_ready && slot != S_CPU)
      cnt_d = (32'(cnt_q) >= STARVE_MAX) ? cnt_q : cnt_q + CW'(1);

    case (state_q)
      C_IDLE: begin
        if (slot == S_CPU)                   state_d = C_ISSUED;
        else if (cpu_req && slot == S_DISP)  state_d = C_WAIT;
      end
      C_WAIT: begin
        if (slot == S_CPU)  state_d = C_ISSUED;
        else if (!cpu_req)  state_d = C_IDLE;
      end
      default: state_d = C_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= C_IDLE;
      tag1_q        <= T_NONE;
      tag2_q        <= T_NONE;
      zero1_q       <= 1'b0;
      zero2_q       <= 1'b0;
      mem_addr_q    <= '0;
      mem_we_q      <= 1'b0;
      mem_wdata_q   <= '0;
      disp_pixel_q  <= '0;
      disp_pvalid_q <= 1'b0;
      cpu_rdata_q   <= '0;
      cpu_rvalid_q  <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      tag1_q        <= tag1_d;
      tag2_q        <= tag2_d;
      zero1_q       <= zero1_d;
      zero2_q       <= zero2_d;
      mem_addr_q    <= mem_addr_d;
      mem_we_q      <= mem_we_d;
      mem_wdata_q   <= mem_wdata_d;
      disp_pixel_q  <= disp_pixel_d;
      disp_pvalid_q <= disp_pvalid_d;
      cpu_rdata_q   <= cpu_rdata_d;
      cpu_rvalid_q  <= cpu_rvalid_d;
      cnt_q         <= cnt_d;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - directed bench for vram_arbiter with a synchronous RAM model.
module tb_vram_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        disp_en;
  logic [9:0]  disp_x;
  logic [8:0]  disp_y;
  logic [7:0]  disp_pixel;
  logic        disp_pvalid;
  logic        cpu_req;
  logic        cpu_we;
  logic [18:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ready;
  logic [7:0]  cpu_rdata;
  logic        cpu_rvalid;
  logic        cpu_starved;
  logic [18:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;

  logic [7:0]  ram [0:307199];
  int          passed = 0;
  int          total  = 0;
  int          bad;

  vram_arbiter dut (
    .clock(clock), .reset(reset),
    .disp_en(disp_en), .disp_x(disp_x), .disp_y(disp_y),
    .disp_pixel(disp_pixel), .disp_pvalid(disp_pvalid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .cpu_starved(cpu_starved),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= (mem_addr < 19'd307200) ? ram[mem_addr] : 8'h00;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ram[i] = 8'(i + 1);
    ram[1283] = 8'hA5;
    reset = 1'b1; disp_en = 1'b0; disp_x = '0; disp_y = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    tick(); tick();
    reset = 1'b0;
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_cpu_ready", cpu_ready, 0);
    check("rst_pvalid", disp_pvalid, 0);
    check("rst_rvalid", cpu_rvalid, 0);
    check("rst_starved", cpu_starved, 0);

    // display read of (3,2) -> address 1283
    disp_en = 1'b1; disp_x = 10'd3; disp_y = 9'd2;
    tick();
    check("t1_mem_addr", mem_addr, 1283);
    check("t1_mem_we", mem_we, 0);
    disp_en = 1'b0;
    tick();
    check("t1_pvalid_k1", disp_pvalid, 0);
    tick();
    check("t1_pvalid_k2", disp_pvalid, 1);
    check("t1_pixel", disp_pixel, 8'hA5);
    tick();
    check("t1_pvalid_after", disp_pvalid, 0);
    check("t1_pixel_hold", disp_pixel, 8'hA5);

    // CPU write then read back
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'd100; cpu_wdata = 8'h3C;
    tick();
    check("t2_wr_we", mem_we, 1);
    check("t2_wr_addr", mem_addr, 100);
    check("t2_wr_data", mem_wdata, 8'h3C);
    check("t2_wr_ready", cpu_ready, 1);
    cpu_req = 1'b0;
    tick();
    check("t2_wr_we_off", mem_we, 0);
    check("t2_wr_ready_off", cpu_ready, 0);
    cpu_req = 1'b1; cpu_we = 1'b0;
    tick();
    check("t2_rd_ready", cpu_ready, 1);
    check("t2_rd_we", mem_we, 0);
    cpu_req = 1'b0;
    tick();
    check("t2_rvalid_k1", cpu_rvalid, 0);
    tick();
    check("t2_rvalid_k2", cpu_rvalid, 1);
    check("t2_rdata", cpu_rdata, 8'h3C);
    tick();
    check("t2_rvalid_after", cpu_rvalid, 0);

    // CPU blocked by 50 cycles of scanout; pixels keep flowing
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'd200; cpu_wdata = 8'h55;
    disp_en = 1'b1; disp_y = 9'd0;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      disp_x = 10'(i);
      tick();
      if (mem_we !== 1'b0 || cpu_ready !== 1'b0) bad++;
      if (i >= 2 && (disp_pvalid !== 1'b1 || disp_pixel !== 8'(i - 1))) bad++;
    end
    check("t3_blocked_cycles", bad, 0);
    disp_en = 1'b0;
    tick();
    check("t3_grant_ready", cpu_ready, 1);
    check("t3_grant_we", mem_we, 1);
    check("t3_grant_addr", mem_addr, 200);
    check("t3_pixel48", {disp_pvalid, disp_pixel}, {1'b1, 8'd49});
    cpu_req = 1'b0;
    tick();
    check("t3_pixel49", {disp_pvalid, disp_pixel}, {1'b1, 8'd50});
    tick();

    // starvation counter under continuous scanout
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'd5;
    disp_en = 1'b1; disp_x = '0; disp_y = '0;
    bad = 0;
    for (int n = 1; n <= 1029; n++) begin
      tick();
      if (n == 1023) check("t4_starved_1023", cpu_starved, 0);
      if (n == 1024) check("t4_starved_1024", cpu_starved, 1);
      if (cpu_starved !== (n >= 1024) || cpu_ready !== 1'b0) bad++;
    end
    check("t4_starve_profile", bad, 0);
    disp_en = 1'b0;
    tick();
    check("t4_grant_ready", cpu_ready, 1);
    check("t4_starved_clear", cpu_starved, 0);
    cpu_req = 1'b0;
    tick(); tick();
    check("t4_rd", {cpu_rvalid, cpu_rdata}, {1'b1, 8'd6});

    // out-of-range display and CPU accesses
    disp_en = 1'b1; disp_x = 10'd640; disp_y = 9'd0;
    tick();
    check("t5_disp_addr_hold", mem_addr, 5);
    disp_en = 1'b0;
    tick(); tick();
    check("t5_disp_oor", {disp_pvalid, disp_pixel}, {1'b1, 8'h00});
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'd307200; cpu_wdata = 8'h77;
    tick();
    check("t5_wr_ready", cpu_ready, 1);
    check("t5_wr_we", mem_we, 0);
    check("t5_wr_addr_hold", mem_addr, 5);
    cpu_req = 1'b0;
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0;
    tick();
    check("t5_rd_ready", cpu_ready, 1);
    cpu_req = 1'b0;
    tick(); tick();
    check("t5_rd_oor", {cpu_rvalid, cpu_rdata}, {1'b1, 8'h00});

    // reset right after a read grant drops the read
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'd100;
    tick();
    check("t6_grant", cpu_ready, 1);
    cpu_req = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_rst_outputs", {mem_addr, mem_we, mem_wdata, cpu_ready, cpu_rvalid, cpu_rdata,
                             disp_pvalid, disp_pixel, cpu_starved}, 0);
    tick();
    check("t6_no_late_rvalid", cpu_rvalid, 0);
    tick();
    check("t6_no_late_rvalid2", cpu_rvalid, 0);
    cpu_req = 1'b1;
    tick();
    check("t6_new_grant", cpu_ready, 1);
    cpu_req = 1'b0;
    tick(); tick();
    check("t6_new_rd", {cpu_rvalid, cpu_rdata}, {1'b1, 8'h3C});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
